// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame decoder.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        CMD,
        LEN,
        PAYLOAD,
        CHK,
        DONE
    } frame_state_t;

    localparam logic [7:0] FRAME_SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit counter that increments on request and sticks at 255.
module sat_cnt8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] cnt
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uart_frame_decoder.sv
// Delineates and verifies SOF/CMD/LEN/payload/checksum frames from the UART RX
// byte stream, holds one verified frame, and counts errors by class.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 14000,
    parameter logic [7:0]  SOF     = FRAME_SOF_DEFAULT
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_err,
    output logic       in_ready,
    output logic       frame_rdy,
    output logic [7:0] frame_cmd,
    output logic [7:0] frame_len,
    input  logic       frame_ack,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] err_chk_cnt,
    output logic [7:0] err_len_cnt,
    output logic [7:0] err_tout_cnt,
    output logic [7:0] err_line_cnt
);

    localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH     = 1 << IDX_W;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT - 1);

    frame_state_t state_q, state_d;
    logic [7:0]   sum_q, sum_d;
    logic [7:0]   idx_q, idx_d;
    logic [7:0]   cmd_q, cmd_d;
    logic [7:0]   len_q, len_d;
    logic [15:0]  gap_q, gap_d;
    logic [7:0]   buf_q [DEPTH];

    logic accept;
    logic active;
    logic buf_we;
    logic inc_chk, inc_len, inc_tout, inc_line;

    assign in_ready = (state_q != DONE);
    assign accept   = in_valid && in_ready;
    assign active   = (state_q == CMD) || (state_q == LEN) ||
                      (state_q == PAYLOAD) || (state_q == CHK);

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        cmd_d    = cmd_q;
        len_d    = len_q;
        gap_d    = gap_q;
        buf_we   = 1'b0;
        inc_chk  = 1'b0;
        inc_len  = 1'b0;
        inc_tout = 1'b0;
        inc_line = 1'b0;

        // Inter-byte gap watchdog; an accepted byte always wins over expiry.
        if (!active || accept) begin
            gap_d = 16'h0000;
        end else if (gap_q == TOUT_LAST) begin
            gap_d    = 16'h0000;
            inc_tout = 1'b1;
            state_d  = HUNT;
        end else begin
            gap_d = gap_q + 16'd1;
        end

        if (accept) begin
            if (in_err && active) begin
                inc_line = 1'b1;
                state_d  = HUNT;
            end else begin
                case (state_q)
                    HUNT: begin
                        if (!in_err && (in_data == SOF)) begin
                            state_d = CMD;
                        end
                    end
                    CMD: begin
                        cmd_d   = in_data;
                        sum_d   = in_data;
                        state_d = LEN;
                    end
                    LEN: begin
                        if (in_data > MAX_LEN_B) begin
                            inc_len = 1'b1;
                            state_d = HUNT;
                        end else begin
                            len_d   = in_data;
                            sum_d   = sum_q + in_data;
                            idx_d   = 8'h00;
                            state_d = (in_data == 8'h00) ? CHK : PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        buf_we = 1'b1;
                        sum_d  = sum_q + in_data;
                        if (idx_q == (len_q - 8'd1)) begin
                            state_d = CHK;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end
                    CHK: begin
                        if (in_data == sum_q) begin
                            state_d = DONE;
                        end else begin
                            inc_chk = 1'b1;
                            state_d = HUNT;
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end else if ((state_q == DONE) && frame_ack) begin
            state_d = HUNT;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= HUNT;
            sum_q   <= 8'h00;
            idx_q   <= 8'h00;
            cmd_q   <= 8'h00;
            len_q   <= 8'h00;
            gap_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else if (buf_we) begin
            buf_q[idx_q[IDX_W-1:0]] <= in_data;
        end
    end

    assign frame_rdy = (state_q == DONE);
    assign frame_cmd = cmd_q;
    assign frame_len = len_q;
    assign rd_data   = (rd_addr < len_q) ? buf_q[rd_addr[IDX_W-1:0]] : 8'h00;

    sat_cnt8 u_cnt_chk  (.clk(Clk), .rst(Rst), .inc(inc_chk),  .cnt(err_chk_cnt));
    sat_cnt8 u_cnt_len  (.clk(Clk), .rst(Rst), .inc(inc_len),  .cnt(err_len_cnt));
    sat_cnt8 u_cnt_tout (.clk(Clk), .rst(Rst), .inc(inc_tout), .cnt(err_tout_cnt));
    sat_cnt8 u_cnt_line (.clk(Clk), .rst(Rst), .inc(inc_line), .cnt(err_line_cnt));

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: stimulus pushes expected frames,
// a monitor pops and checks each held frame, then acknowledges it.
module tb_uart_frame_decoder;

    localparam int TOUT = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_err = 1'b0;
    logic       in_ready;
    logic       frame_rdy;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic       frame_ack = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic [7:0] err_chk_cnt, err_len_cnt, err_tout_cnt, err_line_cnt;

    always #5 clk = ~clk;

    uart_frame_decoder #(.MAX_LEN(16), .TIMEOUT(TOUT), .SOF(8'hA5)) dut (
        .Clk(clk), .Rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_err(in_err), .in_ready(in_ready),
        .frame_rdy(frame_rdy), .frame_cmd(frame_cmd), .frame_len(frame_len),
        .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd_data),
        .err_chk_cnt(err_chk_cnt), .err_len_cnt(err_len_cnt),
        .err_tout_cnt(err_tout_cnt), .err_line_cnt(err_line_cnt)
    );

    typedef struct packed {
        logic [7:0]       cmd;
        logic [7:0]       len;
        logic [15:0][7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] seq[$];
    int         vec_cnt = 0;
    int         miss_cnt = 0;
    logic       mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        int n;
        @(negedge clk);
        in_data  = b;
        in_err   = e;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_stall", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i], 1'b0);
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_err   = 1'b0;
    endtask

    // Expected frame taken from the clean vector currently in seq.
    task automatic push_exp();
        exp_t e;
        e = '0;
        e.cmd = seq[1];
        e.len = seq[2];
        for (int i = 0; i < int'(seq[2]); i++) e.data[i] = seq[3+i];
        exp_q.push_back(e);
    endtask

    // Monitor: checks every held frame, then releases it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_rdy && !rst) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(frame_cmd), 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_cmd", 32'(frame_cmd), 32'(e.cmd));
                    check("frame_len", 32'(frame_len), 32'(e.len));
                    for (int i = 0; i <= int'(e.len); i++) begin
                        rd_addr = 8'(i);
                        #1;
                        if (i < int'(e.len)) check("rd_data", 32'(rd_data), 32'(e.data[i]));
                        else                 check("rd_data_oob", 32'(rd_data), 32'd0);
                    end
                    check("in_ready_held", 32'(in_ready), 32'd0);
                end
                rd_addr = 8'h00;
                @(negedge clk);
                frame_ack = 1'b1;
                @(posedge clk);
                #1;
                frame_ack = 1'b0;
                check("rdy_after_ack", 32'(frame_rdy), 32'd0);
                check("ready_after_ack", 32'(in_ready), 32'd1);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_line;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_frame_rdy", 32'(frame_rdy), 32'd0);
        check("rst_cmd", 32'(frame_cmd), 32'd0);
        check("rst_len", 32'(frame_len), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_cnts", {err_chk_cnt, err_len_cnt, err_tout_cnt, err_line_cnt}, 32'd0);
        rst = 1'b0;

        // Good frame, frame_rdy one edge after the checksum byte.
        seq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h45};
        push_exp();
        send_seq();
        go_idle();
        check("latency_rdy", 32'(frame_rdy), 32'd1);

        // Bad checksum, then a good frame still decodes.
        seq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h46};
        send_seq();
        go_idle();
        check("err_chk", 32'(err_chk_cnt), 32'd1);
        check("no_rdy_bad_chk", 32'(frame_rdy), 32'd0);
        seq = '{8'hA5, 8'h20, 8'h01, 8'h33, 8'h54};
        push_exp();
        send_seq();

        // Noise, over-length, zero length, maximum length.
        seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h11};
        send_seq();
        go_idle();
        check("err_len", 32'(err_len_cnt), 32'd1);
        seq = '{8'hA5, 8'h07, 8'h00, 8'h07};
        push_exp();
        send_seq();
        seq = '{8'hA5, 8'h03, 8'h10,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10,
                8'h9B};
        push_exp();
        send_seq();

        // Timeout after exactly TOUT idle cycles, not one earlier.
        seq = '{8'hA5, 8'h10};
        send_seq();
        go_idle();
        repeat (TOUT - 1) @(negedge clk);
        check("tout_not_yet", 32'(err_tout_cnt), 32'd0);
        @(negedge clk);
        check("err_tout", 32'(err_tout_cnt), 32'd1);

        // Byte on the expiry cycle wins.
        seq = '{8'hA5, 8'h10, 8'h01, 8'h44, 8'h55};
        push_exp();
        send_byte(seq[0], 1'b0);
        send_byte(seq[1], 1'b0);
        go_idle();
        repeat (TOUT - 2) @(negedge clk);
        for (int i = 2; i < 5; i++) send_byte(seq[i], 1'b0);
        go_idle();
        check("tout_byte_wins", 32'(err_tout_cnt), 32'd1);

        // Line error on LEN; errored SOF in HUNT is ignored.
        seq = '{8'hA5, 8'h10};
        send_seq();
        send_byte(8'h02, 1'b1);
        go_idle();
        check("err_line", 32'(err_line_cnt), 32'd1);
        send_byte(8'hA5, 1'b1);
        seq = '{8'hA5, 8'h30, 8'h00, 8'h30};
        push_exp();
        send_seq();
        go_idle();
        check("err_line_hunt", 32'(err_line_cnt), 32'd1);
        check("err_len_hunt", 32'(err_len_cnt), 32'd1);

        // Saturation after 300 line errors.
        exp_line = 1;
        for (int i = 1; i < 300; i++) begin
            send_byte(8'hA5, 1'b0);
            send_byte(8'h00, 1'b1);
            if (exp_line < 255) exp_line++;
            if (i == 200) begin
                go_idle();
                check("err_line_200", 32'(err_line_cnt), 32'd201);
            end
        end
        go_idle();
        check("err_line_sat", 32'(err_line_cnt), 32'(exp_line));

        // Reset mid-frame, then a fresh frame.
        seq = '{8'hA5, 8'h10, 8'h02, 8'h11};
        send_seq();
        go_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_frame_rdy", 32'(frame_rdy), 32'd0);
        check("mid_rst_cmd", 32'(frame_cmd), 32'd0);
        check("mid_rst_len", 32'(frame_len), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        check("mid_rst_cnts", {err_chk_cnt, err_len_cnt, err_tout_cnt, err_line_cnt}, 32'd0);
        seq = '{8'hA5, 8'h40, 8'h01, 8'h99, 8'hDA};
        push_exp();
        send_seq();
        go_idle();

        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("frames_outstanding", 32'(exp_q.size()), 32'd0);
        check("final_cnts", {err_chk_cnt, err_len_cnt, err_tout_cnt, err_line_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
